// File: rtl/socdebug_axis_fifo.sv
// socdebug_axis_fifo: byte-wide AXI-Stream FIFO with tlast, occupancy status and synchronous flush
module socdebug_axis_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_W-1:0]     s_tdata,
  input  logic                  s_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_W-1:0]     m_tdata,
  output logic                  m_tlast,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  fifo_empty,
  output logic                  fifo_full
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  logic [DATA_W:0]       mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   level_next;
  logic                  push, pop;
  assign push = s_tvalid & s_tready;
  assign pop = m_tvalid & m_tready;
  assign {m_tlast, m_tdata} = mem[rd_ptr];
  assign fifo_empty = fifo_level == '0;
  assign fifo_full = fifo_level == FULL;
  // occupancy after this edge; flush overrides any concurrent push or pop
  always_comb
    level_next = flush ? '0 : fifo_level + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
  // storage, pointers and registered handshake flags
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      mem <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      m_tvalid <= 1'b0;
      s_tready <= 1'b0;
    end else begin
      if (push && !flush) mem[wr_ptr] <= {s_tlast, s_tdata};
      wr_ptr <= flush ? '0 : wr_ptr + DEPTH_LOG2'(push);
      rd_ptr <= flush ? '0 : rd_ptr + DEPTH_LOG2'(pop);
      fifo_level <= level_next;
      m_tvalid <= level_next != '0;
      s_tready <= (level_next < FULL) & !flush;
    end
endmodule

// File: tb/tb_socdebug_axis_fifo.sv
// tb_socdebug_axis_fifo: directed self-checking bench for socdebug_axis_fifo
module tb_socdebug_axis_fifo;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       flush = 1'b0;
  logic       s_tvalid = 1'b1;
  logic       s_tready;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tlast = 1'b0;
  logic       m_tvalid;
  logic       m_tready = 1'b0;
  logic [7:0] m_tdata;
  logic       m_tlast;
  logic [4:0] fifo_level;
  logic       fifo_empty, fifo_full;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int sent, recv, cyc;

  socdebug_axis_fifo #(.DATA_W(8), .DEPTH_LOG2(4)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .fifo_level(fifo_level), .fifo_empty(fifo_empty), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) tick;
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tlast", m_tlast, 0);
    s_tvalid = 1'b0;
    resetn = 1'b1;
    #1;
    chk("rel_s_tready_pre", s_tready, 0);
    tick;
    chk("rel_s_tready", s_tready, 1);
    chk("rel_level", fifo_level, 0);

    s_tvalid = 1'b1; s_tdata = 8'hA5; s_tlast = 1'b1;
    tick;
    s_tvalid = 1'b0; s_tlast = 1'b0;
    chk("one_m_tvalid", m_tvalid, 1);
    chk("one_m_tdata", m_tdata, 8'hA5);
    chk("one_m_tlast", m_tlast, 1);
    chk("one_level", fifo_level, 1);
    chk("one_empty", fifo_empty, 0);
    m_tready = 1'b1;
    tick;
    m_tready = 1'b0;
    chk("one_pop_m_tvalid", m_tvalid, 0);
    chk("one_pop_level", fifo_level, 0);
    chk("one_pop_empty", fifo_empty, 1);

    for (int i = 0; i < 16; i++) begin
      chk("fill_s_tready", s_tready, 1);
      s_tvalid = 1'b1; s_tdata = 8'(i);
      tick;
    end
    chk("full_s_tready", s_tready, 0);
    chk("full_flag", fifo_full, 1);
    chk("full_level", fifo_level, 16);
    s_tdata = 8'hEE;
    tick;
    chk("full_hold_level", fifo_level, 16);
    chk("full_head", m_tdata, 8'h00);
    s_tvalid = 1'b0; m_tready = 1'b1;
    tick;
    m_tready = 1'b0;
    chk("unfull_s_tready", s_tready, 1);
    chk("unfull_level", fifo_level, 15);
    chk("unfull_flag", fifo_full, 0);
    chk("unfull_head", m_tdata, 8'h01);

    m_tready = 1'b1;
    repeat (7) tick;
    m_tready = 1'b0;
    chk("conc_start_level", fifo_level, 8);
    chk("conc_start_head", m_tdata, 8'h08);
    for (int i = 8; i < 16; i++) exp_q.push_back(8'(i));
    s_tvalid = 1'b1; m_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_tdata = 8'(8'h40 + i);
      chk("conc_data", m_tdata, exp_q.pop_front());
      exp_q.push_back(8'(8'h40 + i));
      tick;
      chk("conc_level", fifo_level, 8);
    end
    s_tvalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", m_tdata, exp_q.pop_front());
      tick;
    end
    m_tready = 1'b0;
    chk("drain_empty", fifo_empty, 1);
    chk("drain_m_tvalid", m_tvalid, 0);

    sent = 0; recv = 0; cyc = 0;
    while (recv < 40 && cyc < 2000) begin
      s_tvalid = (sent < 40) && ($urandom_range(0, 2) != 0);
      s_tdata = 8'(sent);
      s_tlast = (sent == 9) || (sent == 19) || (sent == 39);
      m_tready = $urandom_range(0, 2) != 0;
      if (m_tvalid && m_tready) begin
        chk("wrap_data", m_tdata, 8'(recv));
        chk("wrap_last", m_tlast, (recv == 9) || (recv == 19) || (recv == 39));
        recv++;
      end
      if (s_tvalid && s_tready) sent++;
      tick;
      cyc++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    chk("wrap_count", recv, 40);
    chk("wrap_empty", fifo_empty, 1);

    for (int i = 0; i < 5; i++) begin
      s_tvalid = 1'b1; s_tdata = 8'(8'h10 + i);
      tick;
    end
    chk("pre_flush_level", fifo_level, 5);
    flush = 1'b1; s_tdata = 8'h99; m_tready = 1'b1;
    tick;
    flush = 1'b0; m_tready = 1'b0; s_tdata = 8'h77;
    chk("flush_level", fifo_level, 0);
    chk("flush_m_tvalid", m_tvalid, 0);
    chk("flush_s_tready", s_tready, 0);
    chk("flush_empty", fifo_empty, 1);
    tick;
    chk("post_flush_s_tready", s_tready, 1);
    chk("post_flush_level", fifo_level, 0);
    tick;
    s_tvalid = 1'b0;
    chk("post_flush_m_tvalid", m_tvalid, 1);
    chk("post_flush_head", m_tdata, 8'h77);
    chk("post_flush_level1", fifo_level, 1);

    s_tvalid = 1'b1; s_tdata = 8'h33;
    repeat (2) tick;
    s_tvalid = 1'b0;
    chk("mid_level", fifo_level, 3);
    #3 resetn = 1'b0;
    #1;
    chk("mid_rst_m_tvalid", m_tvalid, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_s_tready", s_tready, 0);
    chk("mid_rst_m_tdata", m_tdata, 0);
    resetn = 1'b1;
    tick;
    chk("mid_rel_s_tready", s_tready, 1);
    chk("mid_rel_empty", fifo_empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/socdebug_axis_fifo.md
Name: socdebug_axis_fifo

Overview:
- Byte-wide AXI-Stream FIFO that buffers traffic between the FT1248 serial controller and the ADP controller.
- One instance sits on each direction: FT1248 read data goes to the ADP command input, and ADP response data goes to the FT1248 write stream.
- It absorbs the slow, bursty FT1248 serial timing, so the ADP side sees back-to-back beats and the FT1248 side never stalls mid-byte.
- Each entry carries tdata plus tlast. The block provides occupancy status and a synchronous flush.

Parameters:
- DATA_W, 8, payload width per beat in bits.
- DEPTH_LOG2, 4, log2 of the entry count (DEPTH = 2**DEPTH_LOG2). Legal range is 1..8.

Ports:
- clk  input  1  system clock; all logic is posedge-clocked.
- resetn  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all FIFO contents.
- s_tvalid  input  1  upstream beat valid.
- s_tready  output  1  FIFO can accept a beat; registered.
- s_tdata  input  DATA_W  upstream payload.
- s_tlast  input  1  upstream end-of-packet marker.
- m_tvalid  output  1  FIFO holds at least one beat.
- m_tready  input  1  downstream accepts the head beat.
- m_tdata  output  DATA_W  head-of-FIFO payload.
- m_tlast  output  1  head-of-FIFO tlast.
- fifo_level  output  DEPTH_LOG2+1  current number of stored entries.
- fifo_empty  output  1  fifo_level == 0.
- fifo_full  output  1  fifo_level == DEPTH.

Behaviour:
- Reset values, asserted asynchronously:
  - wr_ptr, rd_ptr, fifo_level, m_tvalid and s_tready = 0.
  - fifo_empty = 1, fifo_full = 0.
  - m_tdata and m_tlast = 0, because the storage array is reset to 0.
- s_tready rises on the first clk edge after resetn deasserts.
- Storage:
  - DEPTH entries of DATA_W+1 bits holding {tlast, tdata}.
  - Pointers are DEPTH_LOG2 bits and wrap naturally from DEPTH-1 to 0.
  - fifo_level is a separate counter.
- Push:
  - A push occurs when s_tvalid & s_tready at a clk edge.
  - The FIFO writes mem[wr_ptr] and increments wr_ptr.
- Pop:
  - A pop occurs when m_tvalid & m_tready at a clk edge.
  - rd_ptr increments.
- Output (first-word fall-through):
  - m_tdata and m_tlast are driven from mem[rd_ptr].
  - m_tvalid = (fifo_level != 0), registered.
  - Latency is exactly 1 cycle: a beat accepted at edge k has m_tvalid high in the cycle after edge k.
- Level update:
  - Push only: +1. Pop only: -1. Both or neither: unchanged.
  - fifo_level must never exceed DEPTH or go below 0.
- s_tready is registered. Its next value = (level_next < DEPTH) & !flush.
  - There is no combinational path from m_tready to s_tready.
  - When full, a pop in cycle n raises s_tready in cycle n+1.
  - A simultaneous push and pop at level DEPTH cannot occur, because s_tready is low at that level.
- Simultaneous push and pop with level 1..DEPTH-1: both happen and the level holds.
  - At level 0 a pop cannot occur, because m_tvalid is low.
- m_tvalid rule:
  - Once m_tvalid is high, m_tdata and m_tlast hold stable until popped.
  - The only exception is flush.
- tlast passes through untouched. The FIFO performs no packet-boundary logic.
- Flush:
  - On a clk edge with flush = 1, wr_ptr, rd_ptr and fifo_level clear to 0.
  - m_tvalid and s_tready are 0 in the next cycle.
  - A push or pop presented in the same cycle is discarded; flush has priority.
  - s_tready returns high on the first edge after flush deasserts.
- Reset mid-transfer: all contents are lost immediately and outputs go to reset values. No partial beat is emitted.
- fifo_empty and fifo_full are decoded directly from the registered fifo_level.

Test Plan:
- Reset: hold resetn low with s_tvalid=1 -> s_tready=0, m_tvalid=0, fifo_level=0, fifo_empty=1. One edge after release -> s_tready=1.
- Single beat: push 0xA5 with tlast=1 at edge k, m_tready=0 -> m_tvalid=1 after edge k with m_tdata=0xA5, m_tlast=1, level=1. Then m_tready=1 -> m_tvalid=0 after the next edge.
- Fill (DEPTH=16): push 0x00..0x0F with m_tready=0 -> after the 16th push s_tready=0, fifo_full=1, level=16. One pop -> s_tready=1 one cycle later, level=15.
- Concurrent traffic: reach level 8, then hold s_tvalid=1 and m_tready=1 for 20 cycles -> level stays 8 and output order equals input order.
- Pointer wrap: stream 40 incrementing bytes with random stalls on both sides -> all 40 bytes emerge in order. The tlast flag on bytes 9, 19 and 39 is preserved at the output.
- Flush: at level 5, assert flush for 1 cycle with s_tvalid=1 and m_tready=1 -> next cycle level=0, m_tvalid=0, s_tready=0. s_tready=1 one cycle after flush drops, and the next pushed byte appears first at the output.
